writeback_regfile: RTL and testbench

//  Final pipeline stage behind execute_instruction: commits result/wb_r/wb/v to
//  a 32-entry GPR file and serves two combinational read ports to decode.

---
 rtl/writeback_regfile.sv | 111 +++++++++++
 tb/tb_writeback_regfile.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Writeback stage: 32-entry GPR file with two comb read ports, busy scoreboard, halt/drain FSM.
// Optional WB_BYPASS_EN: write-through reads and hazard masking for same-cycle commits.
module writeback_regfile #(
    parameter int W_OPR = 32,
    parameter int W_RD  = 5,
    parameter int N_REG = 32,
    parameter int W_CNT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    input  logic             wb_i,
    input  logic [W_RD-1:0]  wb_r_i,
    input  logic [W_OPR-1:0] result_i,
    input  logic             hlt_i,
    input  logic             issue_i,
    input  logic             issue_wb_i,
    input  logic [W_RD-1:0]  issue_rd_i,
    input  logic [W_RD-1:0]  rs0_i,
    input  logic [W_RD-1:0]  rs1_i,
    output logic [W_OPR-1:0] rs0_data_o,
    output logic [W_OPR-1:0] rs1_data_o,
    output logic             hazard_o,
    output logic             halted_o,
    output logic [W_CNT-1:0] retire_cnt_o
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    localparam logic [W_CNT-1:0] CNT_ONE = {{(W_CNT-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [W_OPR-1:0]   gpr_q [N_REG];
    logic [N_REG-1:0]   busy_q, busy_d;
    logic [W_CNT-1:0]   retire_cnt_q, retire_cnt_d;
    logic               halted_q;

    logic commit_en, retire_en, issue_en;
    logic byp0, byp1, bypd;

    assign commit_en = wb_i && (state_q != S_HALTED);
    assign retire_en = v_i  && (state_q != S_HALTED);

`ifdef WB_BYPASS_EN
    assign byp0 = commit_en && (wb_r_i == rs0_i);
    assign byp1 = commit_en && (wb_r_i == rs1_i);
    assign bypd = commit_en && (wb_r_i == issue_rd_i);
`else
    assign byp0 = 1'b0;
    assign byp1 = 1'b0;
    assign bypd = 1'b0;
`endif

    // Any state other than RUN stalls decode outright.
    assign hazard_o = (state_q != S_RUN)
                    | (busy_q[rs0_i] & ~byp0)
                    | (busy_q[rs1_i] & ~byp1)
                    | (issue_wb_i & busy_q[issue_rd_i] & ~bypd);

    assign issue_en = issue_i & issue_wb_i & ~hazard_o;

    assign rs0_data_o   = byp0 ? result_i : gpr_q[rs0_i];
    assign rs1_data_o   = byp1 ? result_i : gpr_q[rs1_i];
    assign halted_o     = halted_q;
    assign retire_cnt_o = retire_cnt_q;

    // Issue set is applied after commit clear so it wins on the same register.
    always_comb begin
        busy_d = busy_q;
        if (commit_en) busy_d[wb_r_i] = 1'b0;
        if (issue_en)  busy_d[issue_rd_i] = 1'b1;
    end

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire_en) retire_cnt_d = retire_cnt_q + CNT_ONE;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:    if (hlt_i && v_i) state_d = S_DRAIN;
            S_DRAIN:  if (busy_d == '0) state_d = S_HALTED;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            busy_q       <= '0;
            retire_cnt_q <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            retire_cnt_q <= retire_cnt_d;
            halted_q     <= (state_d == S_HALTED);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REG; i++) gpr_q[i] <= '0;
        end else if (commit_en) begin
            gpr_q[wb_r_i] <= result_i;
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios plus randomized traffic against an array-based model.
module tb_writeback_regfile;

    localparam int W_CNT = 4;

    logic        clk = 1'b0;
    logic        reset, v, wb, hlt, iss, iss_wb;
    logic [4:0]  wb_r, iss_rd, rs0, rs1;
    logic [31:0] result;
    logic [31:0] rs0_data, rs1_data;
    logic        hazard, halted;
    logic [W_CNT-1:0] cnt;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_gpr [32];
    bit          m_busy [32];
    int          m_st;
    int          m_cnt;

    writeback_regfile #(.W_OPR(32), .W_RD(5), .N_REG(32), .W_CNT(W_CNT)) dut (
        .clk(clk), .reset(reset), .v_i(v), .wb_i(wb), .wb_r_i(wb_r), .result_i(result),
        .hlt_i(hlt), .issue_i(iss), .issue_wb_i(iss_wb), .issue_rd_i(iss_rd),
        .rs0_i(rs0), .rs1_i(rs1), .rs0_data_o(rs0_data), .rs1_data_o(rs1_data),
        .hazard_o(hazard), .halted_o(halted), .retire_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    function automatic bit m_byp(logic [4:0] r);
`ifdef WB_BYPASS_EN
        return wb && (m_st != 2) && (wb_r == r);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_hazard();
        if (m_st != 0) return 1'b1;
        return (m_busy[rs0] && !m_byp(rs0)) || (m_busy[rs1] && !m_byp(rs1))
            || (iss_wb && m_busy[iss_rd] && !m_byp(iss_rd));
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] r);
        return m_byp(r) ? result : m_gpr[r];
    endfunction

    task automatic m_update();
        bit haz, commit, retire, issue, all_clear;
        bit nb [32];
        haz    = m_hazard();
        commit = wb && (m_st != 2);
        retire = v && (m_st != 2);
        issue  = iss && iss_wb && !haz;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin m_gpr[i] = 0; m_busy[i] = 0; end
            m_st = 0; m_cnt = 0;
        end else begin
            nb = m_busy;
            if (commit) begin m_gpr[wb_r] = result; nb[wb_r] = 0; end
            if (issue) nb[iss_rd] = 1;
            if (retire) m_cnt = (m_cnt + 1) % (1 << W_CNT);
            all_clear = 1;
            for (int i = 0; i < 32; i++) if (nb[i]) all_clear = 0;
            if (m_st == 0 && hlt && v) m_st = 1;
            else if (m_st == 1 && all_clear) m_st = 2;
            m_busy = nb;
        end
    endtask

    task automatic idle();
        reset = 0; v = 0; wb = 0; hlt = 0; iss = 0; iss_wb = 0;
        wb_r = 0; iss_rd = 0; rs0 = 0; rs1 = 0; result = 0;
    endtask

    task automatic tick();
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); reset = 0;
    endtask

    task automatic test_reset();
        do_reset(); #1;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
        for (int i = 0; i < 32; i++) begin
            rs0 = 5'(i); rs1 = 5'(31 - i); #1;
            checks++;
            if (rs0_data !== 32'h0 || rs1_data !== 32'h0) begin
                failures++; $display("FAIL reset_gpr r%0d got=%h/%h exp=0", i, rs0_data, rs1_data);
            end
        end
    endtask

    task automatic test_commit();
        do_reset();
        wb = 1; wb_r = 3; result = 32'hDEADBEEF; v = 1; tick();
        idle(); rs0 = 3; #1;
        checks++; if (rs0_data !== 32'hDEADBEEF) begin failures++; $display("FAIL commit_r3 got=%h exp=deadbeef", rs0_data); end
        checks++; if (cnt !== 4'd1) begin failures++; $display("FAIL commit_cnt got=%0d exp=1", cnt); end
        rs1 = 0; #1;
        checks++; if (rs1_data !== 32'h0) begin failures++; $display("FAIL commit_r0_untouched got=%h exp=0", rs1_data); end
    endtask

    task automatic test_raw();
        do_reset();
        iss = 1; iss_wb = 1; iss_rd = 5; tick();
        idle(); rs1 = 5; #1;
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL raw_busy got=%b exp=1", hazard); end
        wb = 1; wb_r = 5; result = 32'h1234_5678; #1;
`ifdef WB_BYPASS_EN
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL raw_bypass_hazard got=%b exp=0", hazard); end
        checks++; if (rs1_data !== 32'h1234_5678) begin failures++; $display("FAIL raw_bypass_data got=%h exp=12345678", rs1_data); end
        tick();
`else
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL raw_commit_hazard got=%b exp=1", hazard); end
        checks++; if (rs1_data !== 32'h0) begin failures++; $display("FAIL raw_precommit_data got=%h exp=0", rs1_data); end
        tick();
`endif
        idle(); rs1 = 5; #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL raw_after_hazard got=%b exp=0", hazard); end
        checks++; if (rs1_data !== 32'h1234_5678) begin failures++; $display("FAIL raw_after_data got=%h exp=12345678", rs1_data); end
    endtask

    task automatic test_set_wins();
        do_reset();
        wb = 1; wb_r = 7; result = 32'h77; iss = 1; iss_wb = 1; iss_rd = 7; tick();
        idle(); rs0 = 7; #1;
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL set_wins_hazard got=%b exp=1", hazard); end
        rs0 = 6; iss_wb = 1; iss_rd = 7; #1;
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL waw_hazard got=%b exp=1", hazard); end
    endtask

    task automatic test_halt();
        do_reset();
        iss = 1; iss_wb = 1; iss_rd = 2; tick();
        idle(); hlt = 1; v = 1; tick();
        idle(); iss = 1; iss_wb = 1; iss_rd = 4; #1;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL drain_halted got=%b exp=0", halted); end
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL drain_hazard got=%b exp=1", hazard); end
        tick();
        idle(); wb = 1; wb_r = 2; result = 32'h22; tick();
        idle(); #1;
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halted_after_drain got=%b exp=1", halted); end
        wb = 1; wb_r = 1; result = 32'h1111; v = 1; tick();
        idle(); rs0 = 1; rs1 = 2; #1;
        checks++; if (rs0_data !== 32'h0) begin failures++; $display("FAIL halted_write_r1 got=%h exp=0", rs0_data); end
        checks++; if (rs1_data !== 32'h22) begin failures++; $display("FAIL halted_read_r2 got=%h exp=22", rs1_data); end
        checks++; if (cnt !== 4'd1) begin failures++; $display("FAIL halted_cnt got=%0d exp=1", cnt); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halted_sticky got=%b exp=1", halted); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            idle(); v = 1; tick(); idle(); #1;
            checks++;
            if (cnt !== 4'(i % 16)) begin failures++; $display("FAIL wrap_cnt step=%0d got=%0d exp=%0d", i, cnt, i % 16); end
        end
    endtask

    task automatic test_drain_reset();
        do_reset();
        wb = 1; wb_r = 9; result = 32'h99; iss = 1; iss_wb = 1; iss_rd = 9; v = 1; tick();
        idle(); hlt = 1; v = 1; tick();
        idle(); reset = 1; wb = 1; wb_r = 9; result = 32'h55; tick();
        idle(); rs0 = 9; #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL drain_reset_hazard got=%b exp=0", hazard); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL drain_reset_halted got=%b exp=0", halted); end
        checks++; if (rs0_data !== 32'h0) begin failures++; $display("FAIL drain_reset_r9 got=%h exp=0", rs0_data); end
        checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL drain_reset_cnt got=%0d exp=0", cnt); end
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); #1;
            checks++; if (rs1_data !== 32'h0) begin failures++; $display("FAIL drain_reset_gpr r%0d got=%h exp=0", i, rs1_data); end
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int c = 0; c < 100; c++) begin
                idle();
                v      = 1'($urandom_range(0, 1));
                wb     = 1'($urandom_range(0, 1));
                wb_r   = 5'($urandom_range(0, 7));
                result = $urandom;
                hlt    = ($urandom_range(0, 39) == 0);
                iss    = 1'($urandom_range(0, 1));
                iss_wb = ($urandom_range(0, 3) != 0);
                iss_rd = 5'($urandom_range(0, 7));
                rs0    = 5'($urandom_range(0, 7));
                rs1    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                #1;
                checks++;
                if (rs0_data !== m_read(rs0) || rs1_data !== m_read(rs1)) begin
                    failures++; $display("FAIL rand_read seg=%0d cyc=%0d got=%h/%h exp=%h/%h", seg, c, rs0_data, rs1_data, m_read(rs0), m_read(rs1));
                end
                checks++;
                if (hazard !== m_hazard()) begin
                    failures++; $display("FAIL rand_hazard seg=%0d cyc=%0d got=%b exp=%b", seg, c, hazard, m_hazard());
                end
                checks++;
                if (halted !== (m_st == 2) || cnt !== 4'(m_cnt)) begin
                    failures++; $display("FAIL rand_status seg=%0d cyc=%0d halted=%b/%b cnt=%0d/%0d", seg, c, halted, (m_st == 2), cnt, m_cnt);
                end
                tick();
            end
        end
    endtask

    initial begin
        idle();
        @(posedge clk); #1;
        test_reset();
        test_commit();
        test_raw();
        test_set_wins();
        test_halt();
        test_wrap();
        test_drain_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
